// File: rtl/chain_pkg.sv
// Shared state encoding and width limits for the configuration-chain shifter.
package chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } chain_state_e;

  localparam int MAX_BYTE_BITS = 8;
  localparam int CNT_W         = $clog2(MAX_BYTE_BITS);

  // Ones in the low 'bits' positions: the active part of a byte.
  function automatic logic [MAX_BYTE_BITS-1:0] active_mask(input int bits);
    logic [MAX_BYTE_BITS-1:0] m;
    for (int i = 0; i < MAX_BYTE_BITS; i++) begin
      m[i] = (i < bits);
    end
    return m;
  endfunction

endpackage

// File: rtl/chain_shift_reg.sv
// Shift/capture datapath: drives SIN from the write register and collects SOUT
// into the readback register. Capture exists only with CHAIN_SHIFTER_READBACK_EN.
module chain_shift_reg
  import chain_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int BYTE_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     advance,
  input  logic                     capture,
  input  logic                     clear,
  input  logic                     se_next,
  input  logic [MAX_BYTE_BITS-1:0] din,
  input  logic                     sout,
  output logic                     sin,
  output logic [MAX_BYTE_BITS-1:0] rb_data
);

  localparam int W       = MAX_BYTE_BITS;
  localparam int TOP_BIT = BYTE_BITS - 1;
  localparam logic [W-1:0] MASK = active_mask(BYTE_BITS);

  logic [W-1:0] sr_q, sr_d;
  logic         sin_q, sin_d;

  // SIN is registered and shows the head bit of the register as it will be after this edge.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din & MASK;
    end else if (advance) begin
      sr_d = (MSB_FIRST != 0) ? ({sr_q[W-2:0], 1'b0} & MASK) : {1'b0, sr_q[W-1:1]};
    end
    sin_d = 1'b0;
    if (se_next) begin
      sin_d = (MSB_FIRST != 0) ? sr_d[TOP_BIT] : sr_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      sin_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      sin_q <= sin_d;
    end
  end

  assign sin = sin_q;

`ifdef CHAIN_SHIFTER_READBACK_EN
  logic [W-1:0] rb_q, rb_d;
  logic [W-1:0] sout_ext;

  assign sout_ext = {{(W-1){1'b0}}, sout};

  // Captured bits land in the same order SIN sent them, so a loopback reproduces the byte.
  always_comb begin
    rb_d = rb_q;
    if (clear) begin
      rb_d = '0;
    end else if (capture) begin
      if (MSB_FIRST != 0) begin
        rb_d = {rb_q[W-2:0], sout} & MASK;
      end else begin
        rb_d = {1'b0, rb_q[W-1:1]} | (sout_ext << TOP_BIT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  assign rb_data = rb_q;
`else
  logic unused_capture;
  assign unused_capture = ^{sout, capture, clear};
  assign rb_data        = '0;
`endif

endmodule

// File: rtl/chain_shifter.sv
// Byte-to-serial configuration chain shifter with optional SOUT readback
// (HOLD state and capture present only when CHAIN_SHIFTER_READBACK_EN is defined).
module chain_shifter
  import chain_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int BYTE_BITS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_DATA,
  input  logic       ABORT,
  output logic       SIN,
  input  logic       SOUT,
  output logic       SE,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] OUT_DATA,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  chain_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             se_q, se_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             clear_rb;

  // ABORT wins over IN_VALID and OUT_READY; the counter stops at LAST_CNT and never wraps.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = (state_q == IDLE) && in_ready_q && IN_VALID && !ABORT;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
`ifdef CHAIN_SHIFTER_READBACK_EN
          state_d = HOLD;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef CHAIN_SHIFTER_READBACK_EN
      HOLD: begin
        if (ABORT || OUT_READY) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      cnt_d = '0;
    end
    se_d       = (state_d == SHIFT);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      se_q       <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      se_q       <= se_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign clear_rb = accept || (ABORT && (state_q != IDLE));

  chain_shift_reg #(
    .MSB_FIRST (MSB_FIRST),
    .BYTE_BITS (BYTE_BITS)
  ) u_shift_reg (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (accept),
    .advance (state_q == SHIFT),
    .capture (se_q),
    .clear   (clear_rb),
    .se_next (se_d),
    .din     (IN_DATA),
    .sout    (SOUT),
    .sin     (SIN),
    .rb_data (OUT_DATA)
  );

`ifdef CHAIN_SHIFTER_READBACK_EN
  logic out_valid_q, out_valid_d;

  assign out_valid_d = (state_d == HOLD);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_VALID = out_valid_q;
`else
  logic unused_readback;
  assign unused_readback = OUT_READY;
  assign OUT_VALID       = 1'b0;
`endif

  assign IN_READY = in_ready_q;
  assign SE       = se_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_chain_shifter.sv
// Directed bench for chain_shifter: a default MSB-first instance plus a 5-bit LSB-first one.
// Readback expectations follow CHAIN_SHIFTER_READBACK_EN.
module tb_chain_shifter;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       in_valid   = 1'b0;
  logic       abort      = 1'b0;
  logic       out_ready  = 1'b0;
  logic [7:0] in_data    = 8'h00;
  logic       in_ready, sin, se, out_valid, busy;
  logic [7:0] out_data;
  logic       sout;
  logic [7:0] loop_pipe  = 8'h00;
  logic       loop_direct = 1'b0;

  logic       s_in_valid  = 1'b0;
  logic       s_abort     = 1'b0;
  logic       s_out_ready = 1'b0;
  logic [7:0] s_in_data   = 8'h00;
  logic       s_in_ready, s_sin, s_se, s_out_valid, s_busy;
  logic [7:0] s_out_data;
  logic       s_sout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Chain model: eight-stage delay, or a direct wire back from SIN.
  always @(posedge clk) loop_pipe <= {loop_pipe[6:0], sin};
  assign sout   = loop_direct ? sin : loop_pipe[7];
  assign s_sout = s_sin;

  chain_shifter dut (
    .CLK       (clk),
    .RST       (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .ABORT     (abort),
    .SIN       (sin),
    .SOUT      (sout),
    .SE        (se),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .BUSY      (busy)
  );

  chain_shifter #(.MSB_FIRST(0), .BYTE_BITS(5)) dut_short (
    .CLK       (clk),
    .RST       (rst_n),
    .IN_VALID  (s_in_valid),
    .IN_READY  (s_in_ready),
    .IN_DATA   (s_in_data),
    .ABORT     (s_abort),
    .SIN       (s_sin),
    .SOUT      (s_sout),
    .SE        (s_se),
    .OUT_VALID (s_out_valid),
    .OUT_READY (s_out_ready),
    .OUT_DATA  (s_out_data),
    .BUSY      (s_busy)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_write(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic s_drive_write(input logic [7:0] d);
    s_in_data  = d;
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    s_in_data  = 8'h00;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (se !== 1'b0) begin n_err++; $display("[TB] FAIL reset_se: got %b expected 0", se); end
    n_cmp++; if (sin !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sin: got %b expected 0", sin); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (s_se !== 1'b0) begin n_err++; $display("[TB] FAIL reset_s_se: got %b expected 0", s_se); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL release_in_ready_early: got %b expected 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_s_in_ready: got %b expected 1", s_in_ready); end
  endtask

  task automatic test_loopback();
    logic [7:0] pat;
    pat = 8'hA5;
    loop_direct = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL loop_ready: got %b expected 1", in_ready); end
    drive_write(pat);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL loop_se[%0d]: got %b expected 1", i, se); end
      n_cmp++; if (sin !== pat[7-i]) begin n_err++; $display("[TB] FAIL loop_sin[%0d]: got %b expected %b", i, sin, pat[7-i]); end
      @(negedge clk);
    end
    n_cmp++; if (se !== 1'b0) begin n_err++; $display("[TB] FAIL loop_se_end: got %b expected 0", se); end
`ifdef CHAIN_SHIFTER_READBACK_EN
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL loop_out_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL loop_out_data: got %h expected 00", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL loop_valid_drop: got %b expected 0", out_valid); end
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL loop_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL loop_out_data: got %h expected 00", out_data); end
`endif
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL loop_ready_after: got %b expected 1", in_ready); end
  endtask

`ifdef CHAIN_SHIFTER_READBACK_EN
  task automatic test_readback_order();
    loop_direct = 1'b1;
    drive_write(8'h3C);
    repeat (8) @(negedge clk);
    n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("[TB] FAIL order_out_data: got %h expected 3c", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    loop_direct = 1'b1;
    drive_write(8'h5A);
    repeat (8) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("[TB] FAIL bp_data[%0d]: got %h expected 5a", i, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_busy: got %b expected 0", busy); end
  endtask
`else
  task automatic test_no_readback();
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    loop_direct = 1'b1;
    for (int w = 0; w < 3; w++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL nrb_ready[%0d]: got %b expected 1", w, in_ready); end
      drive_write(vals[w]);
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL nrb_se[%0d][%0d]: got %b expected 1", w, i, se); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL nrb_valid[%0d][%0d]: got %b expected 0", w, i, out_valid); end
        @(negedge clk);
      end
      n_cmp++; if (se !== 1'b0) begin n_err++; $display("[TB] FAIL nrb_se_end[%0d]: got %b expected 0", w, se); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL nrb_ready_after[%0d]: got %b expected 1", w, in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL nrb_valid_end[%0d]: got %b expected 0", w, out_valid); end
    end
  endtask
`endif

  task automatic test_abort();
    logic [7:0] pat;
    pat = 8'h81;
    loop_direct = 1'b1;
    drive_write(8'hFF);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL abort_pre_se[%0d]: got %b expected 1", i, se); end
      @(negedge clk);
    end
    n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL abort_4th_se: got %b expected 1", se); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (se !== 1'b0) begin n_err++; $display("[TB] FAIL abort_se: got %b expected 0", se); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_valid[%0d]: got %b expected 0", i, out_valid); end
      @(negedge clk);
    end
    drive_write(pat);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL abort_next_se[%0d]: got %b expected 1", i, se); end
      n_cmp++; if (sin !== pat[7-i]) begin n_err++; $display("[TB] FAIL abort_next_sin[%0d]: got %b expected %b", i, sin, pat[7-i]); end
      @(negedge clk);
    end
`ifdef CHAIN_SHIFTER_READBACK_EN
    n_cmp++; if (out_data !== 8'h81) begin n_err++; $display("[TB] FAIL abort_next_data: got %h expected 81", out_data); end
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL abort_hold_discard: got %h expected 00", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL abort_hold_valid: got %b expected 0", out_valid); end
`endif
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_next_done: got %b expected 0", busy); end
    in_data  = 8'h42;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_idle_block: got %b expected 0", busy); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL abort_idle_then_accept: got %b expected 1", se); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_cleanup: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_shift();
    loop_direct = 1'b1;
    drive_write(8'hFF);
    repeat (3) @(negedge clk);
    n_cmp++; if (se !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mid_pre_se: got %b expected 1", se); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (se !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_se: got %b expected 0", se); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (sin !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_sin: got %b expected 0", sin); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL rst_mid_data: got %h expected 00", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mid_release: got %b expected 1", in_ready); end
  endtask

  task automatic test_short_chain();
    logic [7:0] pat;
    n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL short_ready: got %b expected 1", s_in_ready); end
    s_drive_write(8'h1F);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (s_se !== 1'b1) begin n_err++; $display("[TB] FAIL short_se[%0d]: got %b expected 1", i, s_se); end
      n_cmp++; if (s_sin !== 1'b1) begin n_err++; $display("[TB] FAIL short_sin[%0d]: got %b expected 1", i, s_sin); end
      @(negedge clk);
    end
    n_cmp++; if (s_se !== 1'b0) begin n_err++; $display("[TB] FAIL short_se_end: got %b expected 0", s_se); end
`ifdef CHAIN_SHIFTER_READBACK_EN
    n_cmp++; if (s_out_data !== 8'h1F) begin n_err++; $display("[TB] FAIL short_data: got %h expected 1f", s_out_data); end
`else
    n_cmp++; if (s_out_data !== 8'h00) begin n_err++; $display("[TB] FAIL short_data: got %h expected 00", s_out_data); end
`endif
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    pat = 8'h06;
    s_drive_write(8'hE6);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (s_sin !== pat[i]) begin n_err++; $display("[TB] FAIL short2_sin[%0d]: got %b expected %b", i, s_sin, pat[i]); end
      @(negedge clk);
    end
`ifdef CHAIN_SHIFTER_READBACK_EN
    n_cmp++; if (s_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL short2_valid: got %b expected 1", s_out_valid); end
    n_cmp++; if (s_out_data !== 8'h06) begin n_err++; $display("[TB] FAIL short2_data: got %h expected 06", s_out_data); end
`else
    n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL short2_valid: got %b expected 0", s_out_valid); end
    n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL short2_ready: got %b expected 1", s_in_ready); end
`endif
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    n_cmp++; if (s_busy !== 1'b0) begin n_err++; $display("[TB] FAIL short2_done: got %b expected 0", s_busy); end
  endtask

  initial begin
    $display("[TB] chain_shifter directed bench start");
    test_reset();
    test_loopback();
`ifdef CHAIN_SHIFTER_READBACK_EN
    test_readback_order();
    test_backpressure();
`else
    test_no_readback();
`endif
    test_abort();
    test_reset_mid_shift();
    test_short_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chain_shifter.md
CHAIN_SHIFTER -- requirements
Module: chain_shifter

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift byte bit 7 first, 0 = bit 0 first.
REQ-002 SHALL have parameter BYTE_BITS, default 8, meaning number of chain bits shifted per accepted byte; legal range 1..8.
REQ-003 SHALL have port CLK, input, 1, the single clock, rising edge; all state is in this domain.
REQ-004 SHALL have port RST, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port IN_VALID, input, 1, write-byte valid from the command decoder.
REQ-006 SHALL have port IN_READY, output, 1, block can accept a byte.
REQ-007 SHALL have port IN_DATA, input, 8, byte to shift into the configuration chain.
REQ-008 SHALL have port ABORT, input, 1, synchronous discard of the transfer in progress.
REQ-009 SHALL have port SIN, output, 1, serial data to the chain head.
REQ-010 SHALL have port SOUT, input, 1, serial data from the chain tail.
REQ-011 SHALL have port SE, output, 1, chain shift enable.
REQ-012 SHALL have port OUT_VALID, output, 1, readback byte valid toward the UART TX path.
REQ-013 SHALL have port OUT_READY, input, 1, the consumer accepts the readback byte.
REQ-014 SHALL have port OUT_DATA, output, 8, readback byte.
REQ-015 SHALL have port BUSY, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement three states: IDLE, SHIFT and HOLD.
REQ-017 IN_READY SHALL be high only in IDLE.
REQ-018 SHALL accept a byte on the edge where IN_VALID and IN_READY are both high; it then loads the shift register, clears the bit counter and enters SHIFT.
REQ-019 In SHIFT, SE SHALL be high for exactly BYTE_BITS consecutive cycles; SIN and SE SHALL be registered outputs.
REQ-020 SIN SHALL present the current MSB of the shift register when MSB_FIRST=1, otherwise the current LSB; the shift register SHALL advance one bit per cycle.
REQ-021 On every edge where SE=1, SOUT SHALL be sampled and shifted into the readback register, in the same bit order as SIN.
REQ-022 Latency: for a byte accepted at edge t, SE SHALL be high during cycles t+1..t+BYTE_BITS, and OUT_VALID SHALL rise at cycle t+BYTE_BITS+1.
REQ-023 When BYTE_BITS<8, unused OUT_DATA bits SHALL be zero and unused IN_DATA bits SHALL be ignored; the low BYTE_BITS bits are the active bits.
REQ-024 After the last bit, the block SHALL enter HOLD with OUT_VALID=1 and OUT_DATA stable until the edge where OUT_READY=1, then return to IDLE.
REQ-025 OUT_VALID SHALL NOT depend combinationally on OUT_READY, and there SHALL be no back-to-back acceptance: a new byte is accepted no earlier than the cycle after the HOLD handshake.
REQ-026 ABORT=1 in SHIFT or HOLD SHALL force IDLE on the next edge with SE=0 and OUT_VALID=0, and the partial readback SHALL be discarded.
REQ-027 ABORT=1 in IDLE SHALL block acceptance that cycle; ABORT SHALL take priority over IN_VALID and OUT_READY on the same edge.
REQ-028 The bit counter SHALL saturate at BYTE_BITS-1 and SHALL never wrap within a transfer.

Reset
REQ-029 RST=0 SHALL immediately force IDLE, with SE=0, SIN=0, OUT_VALID=0, OUT_DATA=0, BUSY=0 and the counter at 0.
REQ-030 IN_READY SHALL go high on the first edge after RST deasserts.
REQ-031 Reset mid-SHIFT SHALL leave the chain partially shifted; no recovery is attempted.

Configuration
REQ-032 With macro CHAIN_SHIFTER_READBACK_EN defined, SOUT capture and the HOLD state SHALL be present as described above.
REQ-033 Without CHAIN_SHIFTER_READBACK_EN, SOUT SHALL be ignored, OUT_VALID and OUT_DATA SHALL be tied to 0, HOLD SHALL be removed, and SHIFT SHALL return directly to IDLE after the last bit.

Structure
REQ-034 The state encoding typedef (IDLE/SHIFT/HOLD) and the constant for the maximum BYTE_BITS SHALL live in the shared package chain_pkg.
REQ-035 The shift/capture datapath SHALL be one sub-module, chain_shift_reg, instantiated once; the FSM stays in chain_shifter.

Verification
REQ-036 Loopback test: with SOUT tied to SIN delayed 8 cycles, MSB_FIRST=1, write 0xA5 -> SIN sequence 1,0,1,0,0,1,0,1 with SE high 8 cycles, and OUT_DATA=0x00 (the prior chain contents).
REQ-037 Back-pressure test: hold OUT_READY=0 for 20 cycles -> OUT_VALID and OUT_DATA stable, IN_READY=0 throughout; after OUT_READY=1 for one cycle, IN_READY rises on the next cycle.
REQ-038 Abort test: assert ABORT at the 4th SE cycle -> SE=0 on the next edge, no OUT_VALID pulse, and the next byte is accepted normally.
REQ-039 Reset test: pull RST low mid-SHIFT -> SE=0 and BUSY=0 asynchronously, and all outputs at their reset values.
REQ-040 Short-chain test: with MSB_FIRST=0 and BYTE_BITS=5, write 0x1F -> SE high exactly 5 cycles, SIN=1 on each, and OUT_DATA[7:5]=0.
REQ-041 Macro test: with CHAIN_SHIFTER_READBACK_EN undefined, three writes -> OUT_VALID never asserts and IN_READY returns high one cycle after each last shift.
